// File: rtl/pc_unit.sv
// Program counter unit for the multicycle MIPS datapath.
// Holds PC, branch-target and EPC registers and commits the next PC under
// control-unit strobes (sequential, branch, jump, register jump, exception).
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        branch_ne,
  input  logic [1:0]  pc_source,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] shifted_imm,
  input  logic        target_load,
  input  logic [25:0] instr_index,
  input  logic        exception,
  output logic [31:0] pc,
  output logic [31:0] target,
  output logic [31:0] epc,
  output logic        addr_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] epc_q, epc_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] jump_addr;
  logic [31:0] nxt;
  logic        we;

  // Next-PC candidate selection and write enable from the control strobes.
  always_comb begin
    jump_addr = {pc_q[31:28], instr_index, 2'b00};
    nxt       = alu_result;
    unique case (pc_source)
      2'b00:   nxt = alu_result;
      2'b01:   nxt = target_q;
      2'b10:   nxt = jump_addr;
      default: nxt = EXC_VECTOR;
    endcase
    // Branch taken when the zero flag differs from the BNE select.
    we = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));
  end

  // Next-state for all registers; exception overrides every PC write path.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    addr_err_d = 1'b0;
    target_d   = target_q;
    if (exception) begin
      epc_d = pc_q - 32'd4;
      pc_d  = EXC_VECTOR;
    end else if (we) begin
      if (nxt[1:0] != 2'b00) begin
        addr_err_d = 1'b1;
      end else begin
        pc_d = nxt;
      end
    end
    // Target uses the pre-edge pc; it loads even on an exception cycle.
    if (target_load) begin
      target_d = pc_q + shifted_imm;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      target_q   <= 32'h0;
      epc_q      <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      target_q   <= target_d;
      epc_q      <= epc_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc       = pc_q;
  assign target   = target_q;
  assign epc      = epc_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus randomized cycles checked
// against a cycle-level behavioural model.
module tb_pc_unit;

  localparam logic [31:0] RstPc  = 32'h0000_0000;
  localparam logic [31:0] ExcVec = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, pc_write_cond, branch_ne, alu_zero, target_load, exception;
  logic [1:0]  pc_source;
  logic [31:0] alu_result, shifted_imm;
  logic [25:0] instr_index;
  logic [31:0] pc, target, epc;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  // Model state.
  logic [31:0] m_pc, m_target, m_epc;
  logic        m_err;

  pc_unit #(
    .RESET_PC   (RstPc),
    .EXC_VECTOR (ExcVec)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_source     (pc_source),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .shifted_imm   (shifted_imm),
    .target_load   (target_load),
    .instr_index   (instr_index),
    .exception     (exception),
    .pc            (pc),
    .target        (target),
    .epc           (epc),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".target"}, target, m_target);
    chk({tag, ".epc"}, epc, m_epc);
    chk({tag, ".addr_err"}, {31'b0, addr_err}, {31'b0, m_err});
  endtask

  task automatic model_reset();
    m_pc     = RstPc;
    m_target = 32'h0;
    m_epc    = 32'h0;
    m_err    = 1'b0;
  endtask

  // One clock: drive inputs, predict the architectural result, check after edge.
  task automatic cyc(input string tag, input logic pw, input logic pwc, input logic bne,
                     input logic [1:0] src, input logic [31:0] alu, input logic z,
                     input logic [31:0] imm, input logic tl, input logic [25:0] idx,
                     input logic exc);
    logic [31:0] cand, n_pc, n_target, n_epc;
    logic        take, n_err;
    pc_write = pw; pc_write_cond = pwc; branch_ne = bne; pc_source = src;
    alu_result = alu; alu_zero = z; shifted_imm = imm; target_load = tl;
    instr_index = idx; exception = exc;

    case (src)
      2'd0:    cand = alu;
      2'd1:    cand = m_target;
      2'd2:    cand = (m_pc & 32'hF000_0000) + {4'b0, idx, 2'b00};
      default: cand = ExcVec;
    endcase
    take     = pw || (pwc && ((z && !bne) || (!z && bne)));
    n_pc     = m_pc;
    n_epc    = m_epc;
    n_err    = 1'b0;
    n_target = tl ? m_pc + imm : m_target;
    if (exc) begin
      n_epc = m_pc - 32'd4;
      n_pc  = ExcVec;
    end else if (take) begin
      if (cand % 4 != 0) n_err = 1'b1;
      else n_pc = cand;
    end

    @(posedge clk);
    #1;
    m_pc = n_pc; m_target = n_target; m_epc = n_epc; m_err = n_err;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 2'd0, 32'h0, 0, 32'h0, 0, 26'h0, 0);
  endtask

  task automatic set_pc(input logic [31:0] v);
    cyc("set_pc", 1, 0, 0, 2'd0, v, 0, 32'h0, 0, 26'h0, 0);
  endtask

  initial begin
    reset = 1'b1;
    pc_write = 0; pc_write_cond = 0; branch_ne = 0; pc_source = 2'd0;
    alu_result = 0; alu_zero = 0; shifted_imm = 0; target_load = 0;
    instr_index = 0; exception = 0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Sequential write.
    cyc("seq", 1, 0, 0, 2'd0, 32'h4, 0, 32'h0, 0, 26'h0, 0);
    chk("seq_pc_const", pc, 32'h4);

    // BEQ taken.
    set_pc(32'h100);
    cyc("beq_tl", 0, 0, 0, 2'd0, 32'h0, 0, 32'h20, 1, 26'h0, 0);
    chk("beq_target_const", target, 32'h120);
    cyc("beq_taken", 0, 1, 0, 2'd1, 32'h0, 1, 32'h0, 0, 26'h0, 0);
    chk("beq_taken_const", pc, 32'h120);

    // BEQ not taken.
    set_pc(32'h100);
    cyc("beq_nt", 0, 1, 0, 2'd1, 32'h0, 0, 32'h0, 0, 26'h0, 0);
    chk("beq_nt_const", pc, 32'h100);

    // BNE with negative offset.
    cyc("bne_tl", 0, 0, 0, 2'd0, 32'h0, 0, 32'hFFFF_FFF0, 1, 26'h0, 0);
    chk("bne_target_const", target, 32'hF0);
    cyc("bne_taken", 0, 1, 1, 2'd1, 32'h0, 0, 32'h0, 0, 26'h0, 0);
    chk("bne_taken_const", pc, 32'hF0);

    // Jump.
    set_pc(32'h4000_0010);
    cyc("jump", 1, 0, 0, 2'd2, 32'h0, 0, 32'h0, 0, 26'h0000_040, 0);
    chk("jump_const", pc, 32'h4000_0100);

    // Target wrap.
    set_pc(32'hFFFF_FFFC);
    cyc("tgt_wrap", 0, 0, 0, 2'd0, 32'h0, 0, 32'h8, 1, 26'h0, 0);
    chk("tgt_wrap_const", target, 32'h4);

    // Same-cycle target load and pc_source=01 write uses the old target.
    cyc("tl_and_write", 1, 0, 0, 2'd1, 32'h0, 0, 32'h10, 1, 26'h0, 0);
    chk("tl_and_write_const", pc, 32'h4);

    // Exception priority over a PC write.
    set_pc(32'h208);
    cyc("exc", 1, 0, 0, 2'd0, 32'h300, 0, 32'h0, 0, 26'h0, 1);
    chk("exc_pc_const", pc, 32'h8000_0180);
    chk("exc_epc_const", epc, 32'h204);

    // Exception at pc=0 wraps epc.
    set_pc(32'h0);
    cyc("exc_wrap", 0, 0, 0, 2'd0, 32'h0, 0, 32'h0, 0, 26'h0, 1);
    chk("exc_wrap_const", epc, 32'hFFFF_FFFC);

    // Misaligned register jump.
    set_pc(32'h500);
    cyc("misalign", 1, 0, 0, 2'd0, 32'h1002, 0, 32'h0, 0, 26'h0, 0);
    chk("misalign_err_const", {31'b0, addr_err}, 32'h1);
    chk("misalign_pc_const", pc, 32'h500);
    idle("misalign_after");
    chk("misalign_clear_const", {31'b0, addr_err}, 32'h0);

    // Asynchronous reset between edges.
    cyc("pre_rst", 0, 0, 0, 2'd0, 32'h0, 0, 32'h44, 1, 26'h0, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 reset = 1'b0;

    // Randomized cycles.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] alu;
      alu = $urandom;
      if ($urandom_range(7) != 0) alu[1:0] = 2'b00;
      cyc("rand", 1'($urandom_range(2) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
          2'($urandom_range(3)), alu, 1'($urandom_range(1)), $urandom,
          1'($urandom_range(2) == 0), 26'($urandom), 1'($urandom_range(15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
